mcu_dispatch_ctrl: RTL

MCU_DISPATCH_CTRL -- requirements
Module: mcu_dispatch_ctrl

---
 rtl/mcu_dispatch_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mcu_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// mcu_dispatch_ctrl
//
// Dispatch and stall controller for N_UNITS multi-cycle execution units
// (e.g. fast FPU, slow FPU). Each unit has its own IDLE/BUSY/DONE FSM:
//   IDLE -> BUSY : the instruction in EX targets this unit, it is the
//                  lowest-index target this cycle, the unit's (stale) valid
//                  is low and the cache is not stalling. A one-cycle start
//                  strobe is sent to the unit in that same cycle.
//   BUSY -> DONE : the unit's result valid is sampled high, or the per-unit
//                  timeout counter reaches all-ones first (sticky tmo_err).
//   DONE -> IDLE : EX advances (no hold_ext, no cache_stall).
// The pipeline (F/D/E) is stalled in the issue cycle and in every BUSY cycle;
// a bubble is pushed into MEM for exactly the same cycles.
//
// Handshake: unit_en_pulse[i] is a single-cycle start command with no ready;
// unit_valid[i] is a level that is only honoured while unit i is BUSY. A
// level still high in IDLE or DONE is a stale result and is ignored.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   dispatch_e     [N_UNITS]  instruction in EX targets unit i
//   unit_valid     [N_UNITS]  unit i result valid (level)
//   cache_stall    memory-stage cache stall (blocks issue only)
//   hold_ext       other EX-register hold sources (lw/in/out stall)
//   unit_en_pulse  [N_UNITS]  one-cycle start strobe to unit i
//   busy           [N_UNITS]  unit i is in BUSY
//   mcu_stall      stall F/D/E
//   flush_m        bubble into MEM (same as mcu_stall)
//   tmo_err        [N_UNITS]  sticky timeout flag, cleared only by rst
//   dbg_state      [2*N_UNITS] FSM state of unit i in bits [2*i+1:2*i]
// ---------------------------------------------------------------------------
module mcu_dispatch_ctrl #(
  parameter int N_UNITS = 2,
  parameter int TMO_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_UNITS-1:0]     dispatch_e,
  input  logic [N_UNITS-1:0]     unit_valid,
  input  logic                   cache_stall,
  input  logic                   hold_ext,
  output logic [N_UNITS-1:0]     unit_en_pulse,
  output logic [N_UNITS-1:0]     busy,
  output logic                   mcu_stall,
  output logic                   flush_m,
  output logic [N_UNITS-1:0]     tmo_err,
  output logic [2*N_UNITS-1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [N_UNITS-1:0] sel;
  logic [N_UNITS-1:0] issue;
  logic [N_UNITS-1:0] busy_st;

  // Only the lowest-index requested unit may issue; higher requests are
  // simply not served this cycle.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (dispatch_e[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
    logic [1:0]       state_q;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_inc;
    logic             tmo_q;

    assign cnt_inc = cnt_q + 1'b1;

    // Issue is qualified with rst so no strobe leaves while reset is held.
    assign issue[i] = (state_q == S_IDLE) & sel[i] & ~unit_valid[i] &
                      ~cache_stall & ~rst;

    assign busy_st[i] = (state_q == S_BUSY) & ~rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        tmo_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (issue[i]) begin
              state_q <= S_BUSY;
              cnt_q   <= '0;
            end
          end
          S_BUSY: begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_inc;
            // A valid in the same cycle as the timeout hit takes priority.
            if (unit_valid[i]) begin
              state_q <= S_DONE;
            end else if (cnt_inc == CNT_MAX) begin
              state_q <= S_DONE;
              tmo_q   <= 1'b1;
            end
          end
          S_DONE: begin
            if (!hold_ext && !cache_stall) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign tmo_err[i]           = tmo_q;
    assign dbg_state[2*i +: 2]  = state_q;
  end

  assign unit_en_pulse = issue;
  assign busy          = busy_st;
  assign mcu_stall     = (|issue) | (|busy_st);
  assign flush_m       = mcu_stall;

endmodule
